// File: rtl/button_debouncer.sv
// Synchronizes a raw, bouncing button input and debounces it into a registered level
// with single-cycle RISE/FALL pulses for driving a downstream enabled flip-flop.
module button_debouncer #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BTN,
    output logic LEVEL,
    output logic RISE,
    output logic FALL
);

    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;

    logic [1:0]       w_stateNext;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_levelNext;
    logic             w_riseNext;
    logic             w_fallNext;

    // BTN is asynchronous to CLK; only the second flop is safe to use.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= BTN;
            r_s2 <= r_s1;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_levelNext = r_level;
        w_riseNext  = 1'b0;
        w_fallNext  = 1'b0;
        case (r_state)
            IDLE_LOW: begin
                w_levelNext = 1'b0;
                if (r_s2) begin
                    w_stateNext = WAIT_HIGH;
                    w_cntNext   = CNT_ONE;
                end else begin
                    w_cntNext   = '0;
                end
            end
            WAIT_HIGH: begin
                w_levelNext = 1'b0;
                if (!r_s2) begin
                    w_stateNext = IDLE_LOW;
                    w_cntNext   = '0;
                end else if (r_cnt == STABLE_CNT) begin
                    w_stateNext = IDLE_HIGH;
                    w_cntNext   = '0;
                    w_levelNext = 1'b1;
                    w_riseNext  = 1'b1;
                end else begin
                    w_cntNext   = r_cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                w_levelNext = 1'b1;
                if (!r_s2) begin
                    w_stateNext = WAIT_LOW;
                    w_cntNext   = CNT_ONE;
                end else begin
                    w_cntNext   = '0;
                end
            end
            WAIT_LOW: begin
                w_levelNext = 1'b1;
                if (r_s2) begin
                    w_stateNext = IDLE_HIGH;
                    w_cntNext   = '0;
                end else if (r_cnt == STABLE_CNT) begin
                    w_stateNext = IDLE_LOW;
                    w_cntNext   = '0;
                    w_levelNext = 1'b0;
                    w_fallNext  = 1'b1;
                end else begin
                    w_cntNext   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_stateNext = IDLE_LOW;
                w_cntNext   = '0;
                w_levelNext = 1'b0;
            end
        endcase
    end

    // Level and pulses are registered so downstream logic sees glitch-free signals.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_level <= w_levelNext;
            r_rise  <= w_riseNext;
            r_fall  <= w_fallNext;
        end
    end

    assign LEVEL = r_level;
    assign RISE  = r_rise;
    assign FALL  = r_fall;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios plus random button
// activity compared against a run-length reference model of the debounce rule.
module tb_button_debouncer;

    localparam int STABLE   = 4;
    localparam int CNT_WIDTH = 4;
    // Edge index (first sampling edge = 1) at which a clean change appears on LEVEL.
    localparam int EXP_EDGE = 1 + 2 + STABLE;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    logic BTN   = 1'b0;
    logic LEVEL;
    logic RISE;
    logic FALL;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    button_debouncer #(
        .STABLE_CYCLES(STABLE),
        .CNT_W        (CNT_WIDTH)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .BTN  (BTN),
        .LEVEL(LEVEL),
        .RISE (RISE),
        .FALL (FALL)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: LEVEL flips once the synchronized input has disagreed with it for STABLE+1 edges in a row.
    logic mS1, mS2, mLevel, mRise, mFall;
    int   mRun;
    always @(posedge CLK or negedge RESET) begin : refModel
        int   run;
        logic lvl;
        if (!RESET) begin
            mS1    <= 1'b0;
            mS2    <= 1'b0;
            mLevel <= 1'b0;
            mRise  <= 1'b0;
            mFall  <= 1'b0;
            mRun   <= 0;
        end else begin
            run = (mS2 != mLevel) ? mRun + 1 : 0;
            lvl = mLevel;
            mRise <= 1'b0;
            mFall <= 1'b0;
            if (run == STABLE + 1) begin
                lvl   = ~mLevel;
                run   = 0;
                mRise <= lvl;
                mFall <= ~lvl;
            end
            mRun   <= run;
            mLevel <= lvl;
            mS2    <= mS1;
            mS1    <= BTN;
        end
    end

    always @(negedge CLK) begin
        if (RESET) begin
            checkOutput("model_level", LEVEL, mLevel);
            checkOutput("model_rise", RISE, mRise);
            checkOutput("model_fall", FALL, mFall);
        end
    end

    logic ffQ;
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) ffQ <= 1'b0;
        else if (RISE) ffQ <= LEVEL;
    end

    task automatic runCycles(input int n, output int rises, output int falls);
        rises = 0;
        falls = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (RISE) rises++;
            if (FALL) falls++;
        end
    endtask

    task automatic applyStimulus(input logic value, input int n, output int rises, output int falls);
        BTN = value;
        runCycles(n, rises, falls);
    endtask

    task automatic findPulse(input bit wantRise, input int maxCycles, output int edgeIdx, output int count, output logic levelAt);
        edgeIdx = 0;
        count   = 0;
        levelAt = 1'b0;
        for (int i = 1; i <= maxCycles; i++) begin
            @(negedge CLK);
            if (wantRise ? RISE : FALL) begin
                count++;
                if (edgeIdx == 0) begin
                    edgeIdx = i;
                    levelAt = LEVEL;
                end
            end
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        int   rises, falls, r2, f2, edgeIdx, cnt;
        int   ffRises, ffFalls;
        logic lvl;
        bit   seenFirst, pendingQ;

        // Reset held with BTN high: outputs stay low.
        RESET = 1'b0;
        BTN   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checkOutput("rst_level", LEVEL, 0);
            checkOutput("rst_rise", RISE, 0);
            checkOutput("rst_fall", FALL, 0);
        end
        RESET = 1'b1;
        findPulse(1, 15, edgeIdx, cnt, lvl);
        checkOutput("rst_rise_edge", edgeIdx, EXP_EDGE);
        checkOutput("rst_rise_count", cnt, 1);
        checkOutput("rst_level_at_rise", lvl, 1);

        // Clean press.
        applyStimulus(1'b0, 12, rises, falls);
        checkOutput("pre_press_falls", falls, 1);
        BTN = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge CLK);
            checkOutput("press_rise", RISE, (k == EXP_EDGE) ? 1 : 0);
            checkOutput("press_level", LEVEL, (k >= EXP_EDGE) ? 1 : 0);
            checkOutput("press_fall", FALL, 0);
        end

        // Bounce rejection.
        applyStimulus(1'b0, 12, rises, falls);
        rises = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i % 2 == 0) ? 1'b1 : 1'b0, 2, r2, f2);
            rises += r2;
        end
        checkOutput("bounce_rises", rises, 0);
        BTN = 1'b1;
        findPulse(1, 12, edgeIdx, cnt, lvl);
        checkOutput("bounce_rise_edge", edgeIdx, EXP_EDGE);
        checkOutput("bounce_rise_count", cnt, 1);

        // Release, then a short low glitch.
        BTN = 1'b0;
        findPulse(0, 12, edgeIdx, cnt, lvl);
        checkOutput("release_fall_edge", edgeIdx, EXP_EDGE);
        checkOutput("release_fall_count", cnt, 1);
        checkOutput("release_level_at_fall", lvl, 0);
        applyStimulus(1'b1, 12, rises, falls);
        checkOutput("repress_rises", rises, 1);
        applyStimulus(1'b0, 3, rises, falls);
        applyStimulus(1'b1, 12, r2, f2);
        checkOutput("glitch_falls", falls + f2, 0);
        checkOutput("glitch_rises", rises + r2, 0);
        checkOutput("glitch_level", LEVEL, 1);

        // Asynchronous reset while LEVEL is high.
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1 checkOutput("async_rst_level", LEVEL, 0);
        BTN = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        applyStimulus(1'b0, 4, rises, falls);

        // Reset mid-WAIT_HIGH (counter at 3 after the fifth edge).
        applyStimulus(1'b1, 5, rises, falls);
        checkOutput("midwait_rises", rises, 0);
        #2 RESET = 1'b0;
        #1;
        checkOutput("midwait_rst_level", LEVEL, 0);
        checkOutput("midwait_rst_rise", RISE, 0);
        checkOutput("midwait_rst_fall", FALL, 0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        findPulse(1, 15, edgeIdx, cnt, lvl);
        checkOutput("midwait_rise_edge", edgeIdx, EXP_EDGE);
        checkOutput("midwait_rise_count", cnt, 1);

        // Chained with downstream FF: D = LEVEL, ENABLE = RISE.
        @(negedge CLK);
        BTN   = 1'b0;
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        ffRises   = 0;
        ffFalls   = 0;
        seenFirst = 1'b0;
        pendingQ  = 1'b0;
        for (int p = 0; p < 10; p++) begin
            for (int half = 0; half < 2; half++) begin
                BTN = (half == 0) ? 1'b1 : 1'b0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge CLK);
                    if (pendingQ) begin
                        checkOutput("ff_q_after_rise", ffQ, 1);
                        pendingQ = 1'b0;
                    end
                    if (RISE) begin
                        ffRises++;
                        if (!seenFirst) begin
                            checkOutput("ff_q_at_rise", ffQ, 0);
                            seenFirst = 1'b1;
                            pendingQ  = 1'b1;
                        end
                    end
                    if (FALL) ffFalls++;
                end
            end
        end
        checkOutput("ff_rise_count", ffRises, 10);
        checkOutput("ff_fall_count", ffFalls, 10);
        checkOutput("ff_q_final", ffQ, 1);

        // Random button activity against the reference model.
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 9)), rises, falls);
        end
        applyStimulus(1'b1, 12, rises, falls);
        checkOutput("random_settle_level", LEVEL, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
